// File: rtl/pim_dma_pkg.sv
// Shared types and constants for the PIM DMA copy controller.
package pim_dma_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR,
    DONE
  } dma_state_e;

  localparam int unsigned WORD_BYTES = 4;
  localparam int unsigned ALIGN_BITS = 2;

endpackage

// File: rtl/pim_dma_ctrl_if.sv
// DMEM read port and PIM write port seen by the DMA controller.
interface pim_dma_ctrl_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  logic              dmem_req_o;
  logic [ADDR_W-1:0] dmem_addr_o;
  logic              dmem_gnt_i;
  logic              dmem_rvalid_i;
  logic [DATA_W-1:0] dmem_rdata_i;
  logic              pim_valid_o;
  logic [ADDR_W-1:0] pim_addr_o;
  logic [DATA_W-1:0] pim_data_o;
  logic              pim_ready_i;

  modport master (
    output dmem_req_o, dmem_addr_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    output pim_valid_o, pim_addr_o, pim_data_o,
    input  pim_ready_i
  );

  modport slave (
    input  dmem_req_o, dmem_addr_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    input  pim_valid_o, pim_addr_o, pim_data_o,
    output pim_ready_i
  );

endinterface

// File: rtl/pim_dma_ctrl.sv
// Word-by-word DMEM -> PIM copy sequencer launched by a PIM opcode;
// holds the pipeline stalled until the last PIM write is accepted.
module pim_dma_ctrl
  import pim_dma_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dma_en_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              stall_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  pim_dma_ctrl_if.master    bus
);

  dma_state_e        state, state_nx;
  logic [ADDR_W-1:0] cur_src, cur_dst;
  logic [LEN_W-1:0]  remaining;
  logic [DATA_W-1:0] data_buf;
  logic              err_q, err_nx;
  logic              misaligned;

  assign misaligned = (|src_addr_i[ALIGN_BITS-1:0]) || (|dst_addr_i[ALIGN_BITS-1:0]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cur_src   <= '0;
      cur_dst   <= '0;
      remaining <= '0;
      data_buf  <= '0;
      err_q     <= 1'b0;
    end else begin
      state <= state_nx;
      err_q <= err_nx;
      case (state)
        IDLE: begin
          if (dma_en_i) begin
            cur_src   <= src_addr_i;
            cur_dst   <= dst_addr_i;
            remaining <= len_i;
          end
        end
        RD_WAIT: begin
          if (bus.dmem_rvalid_i) data_buf <= bus.dmem_rdata_i;
        end
        WR: begin
          // Addresses wrap modulo 2^ADDR_W; the counter only ever decrements from len.
          if (bus.pim_ready_i) begin
            cur_src   <= cur_src + ADDR_W'(WORD_BYTES);
            cur_dst   <= cur_dst + ADDR_W'(WORD_BYTES);
            remaining <= remaining - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (dma_en_i) begin
          if (misaligned)       err_nx   = 1'b1;
          else if (len_i == '0) state_nx = DONE;
          else                  state_nx = RD_REQ;
        end
      end
      RD_REQ:  if (bus.dmem_gnt_i)    state_nx = RD_WAIT;
      RD_WAIT: if (bus.dmem_rvalid_i) state_nx = WR;
      WR: begin
        if (bus.pim_ready_i) state_nx = (remaining == LEN_W'(1)) ? DONE : RD_REQ;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // Launches are only accepted in IDLE; anything else is flagged and dropped.
    if (dma_en_i && (state != IDLE)) err_nx = 1'b1;
  end

  assign busy_o  = (state != IDLE);
  assign stall_o = busy_o;
  assign done_o  = (state == DONE);
  assign err_o   = err_q;

  assign bus.dmem_req_o  = (state == RD_REQ);
  assign bus.dmem_addr_o = (state == RD_REQ) ? cur_src : '0;
  assign bus.pim_valid_o = (state == WR);
  assign bus.pim_addr_o  = (state == WR) ? cur_dst : '0;
  assign bus.pim_data_o  = (state == WR) ? data_buf : '0;

endmodule

// File: tb/tb_pim_dma_ctrl.sv
// Directed self-checking bench for pim_dma_ctrl with a cycle-stepped DMEM/PIM responder.
module tb_pim_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        dma_en;
  logic [31:0] src, dst;
  logic [15:0] len;
  logic        stall, busy, done, err;

  pim_dma_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  pim_dma_ctrl #(.ADDR_W(32), .DATA_W(32), .LEN_W(16)) u_dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .dma_en_i   (dma_en),
    .src_addr_i (src),
    .dst_addr_i (dst),
    .len_i      (len),
    .stall_o    (stall),
    .busy_o     (busy),
    .done_o     (done),
    .err_o      (err),
    .bus        (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int          rd_cnt, wr_cnt, stall_cnt, done_cnt, err_cnt;
  logic [31:0] rd_addr [16];
  logic [31:0] wr_addr [16];
  logic [31:0] wr_data [16];
  bit          unstable, timed_out;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the launch edge.
  task automatic launch(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
    src = s; dst = d; len = l; dma_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dma_en = 1'b0;
  endtask

  // Steps cycles at negedges acting as DMEM and PIM until done_o is seen.
  task automatic run(input int gnt_dly, input int rdy_dly, input int inj_cycle,
                     input int abort_word, input int budget);
    int          gwait, rwait;
    bit          gnt_prev, req_hold, wr_hold, fin;
    logic [31:0] gaddr_prev, hold_addr, hold_paddr, hold_pdata;
    rd_cnt = 0; wr_cnt = 0; stall_cnt = 0; done_cnt = 0; err_cnt = 0;
    unstable = 1'b0; timed_out = 1'b1;
    gwait = 0; rwait = 0; gnt_prev = 1'b0; req_hold = 1'b0; wr_hold = 1'b0; fin = 1'b0;
    gaddr_prev = '0; hold_addr = '0; hold_paddr = '0; hold_pdata = '0;
    for (int cyc = 0; cyc < budget && !fin; cyc++) begin
      if (abort_word >= 0 && bus.pim_valid_o && wr_cnt == abort_word) begin
        rst = 1'b1;
        bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0; bus.pim_ready_i = 1'b0;
        #1;
        check("rst_ctl_outs", {stall, busy, done, err, bus.dmem_req_o, bus.pim_valid_o}, '0);
        check("rst_addr_outs", {bus.dmem_addr_o, bus.pim_addr_o}, '0);
        check("rst_pim_data", bus.pim_data_o, '0);
        fin = 1'b1; timed_out = 1'b0;
      end else begin
        if (stall) stall_cnt++;
        if (err)   err_cnt++;
        if (done) begin done_cnt++; fin = 1'b1; timed_out = 1'b0; end
        dma_en = (cyc == inj_cycle);
        if (cyc == inj_cycle) begin src = 32'h200; dst = 32'h9000; len = 16'd7; end
        bus.dmem_rvalid_i = gnt_prev;
        bus.dmem_rdata_i  = gnt_prev ? (gaddr_prev ^ 32'hCAFE_0000) : 32'hDEAD_BEEF;
        if (req_hold && (!bus.dmem_req_o || bus.dmem_addr_o != hold_addr)) unstable = 1'b1;
        if (wr_hold && (!bus.pim_valid_o || bus.pim_addr_o != hold_paddr ||
                        bus.pim_data_o != hold_pdata)) unstable = 1'b1;
        gnt_prev = 1'b0; req_hold = 1'b0; wr_hold = 1'b0;
        bus.dmem_gnt_i = 1'b0; bus.pim_ready_i = 1'b0;
        if (bus.dmem_req_o) begin
          if (gwait >= gnt_dly) begin
            bus.dmem_gnt_i = 1'b1; gnt_prev = 1'b1; gaddr_prev = bus.dmem_addr_o;
            if (rd_cnt < 16) rd_addr[rd_cnt] = bus.dmem_addr_o;
            rd_cnt++; gwait = 0;
          end else begin
            gwait++; req_hold = 1'b1; hold_addr = bus.dmem_addr_o;
          end
        end
        if (bus.pim_valid_o) begin
          if (rwait >= rdy_dly) begin
            bus.pim_ready_i = 1'b1;
            if (wr_cnt < 16) begin
              wr_addr[wr_cnt] = bus.pim_addr_o;
              wr_data[wr_cnt] = bus.pim_data_o;
            end
            wr_cnt++; rwait = 0;
          end else begin
            rwait++; wr_hold = 1'b1;
            hold_paddr = bus.pim_addr_o; hold_pdata = bus.pim_data_o;
          end
        end
      end
      if (!fin) @(negedge clk);
    end
    dma_en = 1'b0; bus.dmem_rvalid_i = 1'b0;
    bus.dmem_gnt_i = 1'b0; bus.pim_ready_i = 1'b0;
    if (timed_out) check("timeout", 1, 0);
  endtask

  initial begin
    rst = 1'b1; dma_en = 1'b0; src = '0; dst = '0; len = '0;
    bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0;
    bus.dmem_rdata_i = '0; bus.pim_ready_i = 1'b0;
    #1;
    check("reset_ctl", {stall, busy, done, err, bus.dmem_req_o, bus.pim_valid_o}, '0);
    check("reset_bus", {bus.dmem_addr_o, bus.pim_addr_o}, '0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Basic 3-word copy at full rate
    launch(32'h100, 32'h8000, 16'd3);
    run(0, 0, -1, -1, 100);
    check("t1_rd_cnt", rd_cnt, 3);
    check("t1_rd0", rd_addr[0], 32'h100);
    check("t1_rd1", rd_addr[1], 32'h104);
    check("t1_rd2", rd_addr[2], 32'h108);
    check("t1_wr_cnt", wr_cnt, 3);
    check("t1_wa0", wr_addr[0], 32'h8000);
    check("t1_wa1", wr_addr[1], 32'h8004);
    check("t1_wa2", wr_addr[2], 32'h8008);
    check("t1_wd0", wr_data[0], 32'hCAFE_0100);
    check("t1_wd1", wr_data[1], 32'hCAFE_0104);
    check("t1_wd2", wr_data[2], 32'hCAFE_0108);
    check("t1_done", done_cnt, 1);
    check("t1_stall", stall_cnt, 10);
    check("t1_err", err_cnt, 0);
    @(negedge clk);
    check("t1_idle", {busy, done}, 2'b00);

    // Zero-length launch
    launch(32'h100, 32'h8000, 16'd0);
    run(0, 0, -1, -1, 20);
    check("t2_rd_cnt", rd_cnt, 0);
    check("t2_wr_cnt", wr_cnt, 0);
    check("t2_done", done_cnt, 1);
    check("t2_stall", stall_cnt, 1);
    @(negedge clk);

    // Backpressure on both ports
    launch(32'h300, 32'hA000, 16'd2);
    run(3, 5, -1, -1, 200);
    check("t3_stable", unstable, 0);
    check("t3_rd_cnt", rd_cnt, 2);
    check("t3_wr_cnt", wr_cnt, 2);
    check("t3_wa0", wr_addr[0], 32'hA000);
    check("t3_wa1", wr_addr[1], 32'hA004);
    check("t3_wd0", wr_data[0], 32'hCAFE_0300);
    check("t3_wd1", wr_data[1], 32'hCAFE_0304);
    check("t3_done", done_cnt, 1);
    @(negedge clk);

    // Misaligned source
    launch(32'h102, 32'h8000, 16'd2);
    check("t4_err", err, 1'b1);
    check("t4_stall", stall, 1'b0);
    @(negedge clk);
    check("t4_err_pulse", err, 1'b0);
    check("t4_idle", {busy, bus.dmem_req_o}, 2'b00);

    // Launch strobe while busy
    launch(32'h400, 32'hB000, 16'd3);
    run(0, 0, 2, -1, 100);
    check("t5_err_cnt", err_cnt, 1);
    check("t5_wr_cnt", wr_cnt, 3);
    check("t5_wa2", wr_addr[2], 32'hB008);
    check("t5_wd0", wr_data[0], 32'hCAFE_0400);
    check("t5_wd2", wr_data[2], 32'hCAFE_0408);
    check("t5_stall", stall_cnt, 10);
    check("t5_done", done_cnt, 1);
    @(negedge clk);

    // Source address wraps past the top of memory
    launch(32'hFFFF_FFF8, 32'h40, 16'd3);
    run(0, 0, -1, -1, 100);
    check("t6_rd0", rd_addr[0], 32'hFFFF_FFF8);
    check("t6_rd1", rd_addr[1], 32'hFFFF_FFFC);
    check("t6_rd2", rd_addr[2], 32'h0000_0000);
    check("t6_wa2", wr_addr[2], 32'h48);
    check("t6_wd2", wr_data[2], 32'hCAFE_0000);
    @(negedge clk);

    // Reset during the write of word 2 of 4, then a fresh launch
    launch(32'h600, 32'hD000, 16'd4);
    run(0, 2, -1, 1, 100);
    check("t7_no_done", done_cnt, 0);
    @(negedge clk);
    check("t7_held_rst", {busy, done}, 2'b00);
    rst = 1'b0;
    @(negedge clk);
    launch(32'h500, 32'hC000, 16'd2);
    run(0, 0, -1, -1, 100);
    check("t7_wr_cnt", wr_cnt, 2);
    check("t7_wa1", wr_addr[1], 32'hC004);
    check("t7_wd0", wr_data[0], 32'hCAFE_0500);
    check("t7_wd1", wr_data[1], 32'hCAFE_0504);
    check("t7_done", done_cnt, 1);
    check("t7_stall", stall_cnt, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
